vs_fp_dot_product: RTL and testbench
====================================

Name: vs_fp_dot_product

Overview:
- Streaming fixed-point dot-product engine; sits directly downstream of the fixed-point multiply/MAC primitives and feeds vector-reduction consumers (correlators, sparse-recovery inner loops).
- Accepts element pairs (a, b) in Q format over a valid/ready stream and multiplies them in a registered stage.
- Accumulates the products in a wide accumulator and emits one Q-format result per vector, framed by an in_last flag, over a valid/ready output stream.

Parameters:
- Q, 15, fractional bits of the signed 32-bit fixed-point format (fp_32_t).
- ACC_W, 64, internal accumulator width in bits; must be at least 48.
- CNT_W, 16, width of the element counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  element pair valid.
- in_ready  out  1  block accepts an element pair this cycle.
- in_a  in  32  signed Q operand a.
- in_b  in  32  signed Q operand b.
- in_last  in  1  marks the final element of the current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  signed Q dot product.
- out_count  out  CNT_W  number of elements in the vector; saturates at all-ones.
- out_ovf  out  1  final accumulator value lies outside the signed 32-bit range.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: in_ready=0 during reset and 1 in the cycle after reset deasserts; out_valid=0, out_result=0, out_count=0, out_ovf=0; accumulator, counter and stage-1 registers cleared; state=ACCUM.
- Accept: a beat is accepted on a rising edge where in_valid and in_ready are both 1.
- Stage 1 (registered):
  - s1_prod = (sign-extended 64-bit a*b) >>> Q, an arithmetic shift that truncates toward minus infinity.
  - s1_valid and s1_last are registered alongside s1_prod.
- Stage 2:
  - When s1_valid, acc <= acc + sign-extend(s1_prod) at ACC_W bits; count <= count+1, saturating.
  - acc wraps modulo 2^ACC_W. This is documented as not reachable for vectors shorter than 2^16 elements.
- States:
  - ACCUM: in_ready=1.
    - Accepting a beat with in_last=1 moves to DRAIN and drops in_ready the next cycle.
  - DRAIN: in_ready=0.
    - Stage 2 consumes the final s1 beat.
    - Outputs are then loaded and out_valid=1.
    - acc and count are cleared in the same edge.
    - Moves to HOLD.
  - HOLD: in_ready=0.
    - out_result, out_count and out_ovf stay stable while out_valid=1 and out_ready=0.
    - When out_valid and out_ready are both 1: out_valid=0, in_ready=1 next cycle, move to ACCUM.
- Latency: out_valid rises 2 cycles after the edge that accepts the last beat. Throughput is one element per cycle within a vector, plus 3 idle input cycles between vectors when out_ready is held high.
- Output formation (acc_final = acc including the last product):
  - out_ovf = (acc_final > 2^31-1) or (acc_final < -2^31).
  - out_result is chosen per the Optional Feature.
- A vector always has at least 1 element; in_last on the first beat yields a single-product result with count=1.
- in_valid while in_ready=0 is ignored. in_a, in_b and in_last are don't-care when in_valid=0.
- Reset in any state: the partial vector and any pending result are discarded; no out_valid pulse is produced.
- out_count saturation does not affect acc.

Optional Feature:
- Macro: VS_FP_DOT_SAT_EN.
- Defined:
  - out_result = 32'h7FFFFFFF if acc_final > 2^31-1.
  - out_result = 32'h80000000 if acc_final < -2^31.
  - Otherwise out_result = acc_final[31:0].
- Undefined:
  - out_result = acc_final[31:0] (two's-complement wrap).
- out_ovf behaves identically in both builds.

Test Plan:
- Sum of squares, out_ready=1:
  - Stimulus: a=b={1,2,3,4,5,4,3,2,1}<<15, in_last on the 9th beat.
  - Response: out_result=85<<15, out_count=9, out_ovf=0, out_valid exactly 2 cycles after the last accept.
- Signed fractions, single beat with in_last:
  - Stimulus: a=1.5 (49152), b=-2.25 (-73728).
  - Response: out_result=-110592 (-3.375), out_count=1.
- Truncation:
  - Stimulus: a=1, b=1 (LSBs), single beat.
  - Response: out_result=0.
  - Stimulus: a=-1, b=1.
  - Response: out_result=-1 (floor).
- Overflow:
  - Stimulus: two beats a=b=200<<15 (acc_final=80000<<15).
  - Response, SAT_EN build: out_result=32'h7FFFFFFF, out_ovf=1.
  - Response, non-SAT build: out_result=(80000<<15) mod 2^32 as signed, out_ovf=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Response: out_result, out_count and out_ovf stable; in_ready=0 throughout.
  - Stimulus: out_ready=1 for one cycle.
  - Response: out_valid=0, then in_ready=1 the next cycle; a 3-element vector sent afterward yields the correct independent result.
- Reset mid-vector:
  - Stimulus: accept 4 beats without in_last, assert reset for 1 cycle, then send a=b={2,3}<<15 with in_last on the 2nd beat.
  - Response: out_result=13<<15, out_count=2, no out_valid before that result.

Source files
------------

// File: rtl/vs_fp_dot_product_if.sv
// Stream interface for vs_fp_dot_product.
//   Input stream : in_valid / in_ready handshake carrying the operand pair
//                  in_a, in_b (signed Q format) and the end-of-vector flag in_last.
//   Output stream: out_valid / out_ready handshake carrying out_result (signed Q),
//                  out_count (elements in the vector, saturating) and out_ovf.
//   modport master: the producer of element pairs and the consumer of results.
//   modport slave : the dot-product engine.
interface vs_fp_dot_product_if #(
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [31:0]      in_a;
  logic signed [31:0]      in_b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [31:0]      out_result;
  logic        [CNT_W-1:0] out_count;
  logic                    out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count, out_ovf
  );
endinterface

// File: rtl/vs_fp_dot_product.sv
// Streaming fixed-point dot-product engine.
//   Element pairs (a, b) in signed Q format are multiplied in a registered
//   stage, accumulated in an ACC_W-bit accumulator and, once the beat flagged
//   in_last has been folded in, one Q-format result per vector is presented on
//   the output stream and held until the consumer takes it.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - vs_fp_dot_product_if.slave (in_valid/in_ready/in_a/in_b/in_last,
//           out_valid/out_ready/out_result/out_count/out_ovf)
// Build option:
//   VS_FP_DOT_SAT_EN - when defined, out_result saturates to the signed 32-bit
//   range; otherwise it is the low 32 bits of the accumulator (wrap).
//   out_ovf flags an out-of-range accumulator in both builds.
// Timing: out_valid rises two edges after the edge that accepts the last beat;
// with out_ready held high there are three idle input cycles between vectors.
module vs_fp_dot_product #(
  parameter int Q     = 15,
  parameter int ACC_W = 64,
  parameter int CNT_W = 16
) (
  input logic              clock,
  input logic              reset,
  vs_fp_dot_product_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t                   state;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic signed [DATA_W-1:0] out_result_r;
  logic        [CNT_W-1:0]  out_count_r;
  logic                     out_ovf_r;

  logic                     accept_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic        [CNT_W-1:0]  cnt_p2;
  logic signed [ACC_W-1:0]  acc_next;

  // True when the accumulator does not fit in signed DATA_W bits: the bits
  // above the result sign bit are not a pure sign extension.
  function automatic logic acc_ovf(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] hi;
    hi = v[ACC_W-1:DATA_W-1];
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic signed [DATA_W-1:0] fmt_result(input logic signed [ACC_W-1:0] v);
`ifdef VS_FP_DOT_SAT_EN
    if (acc_ovf(v))
      return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Stage 0: handshake and full-width product, rescaled by an arithmetic
  // shift (floor toward minus infinity).
  assign accept_p0 = bus.in_valid && in_ready_r;
  assign prod_p0   = (PROD_W'(bus.in_a) * PROD_W'(bus.in_b)) >>> Q;

  // Stage 2 adder input: product sign-extended to the accumulator width.
  assign acc_next  = acc_p2 + ACC_W'(prod_p1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ACCUM;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_result_r <= '0;
      out_count_r  <= '0;
      out_ovf_r    <= 1'b0;
      prod_p1      <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      acc_p2       <= '0;
      cnt_p2       <= '0;
    end else begin
      // Stage 0 -> 1: register the product with its valid/last tags.
      vld_p1  <= accept_p0;
      last_p1 <= accept_p0 && bus.in_last;
      if (accept_p0)
        prod_p1 <= prod_p0;

      // Stage 1 -> 2: accumulate; the element count saturates, acc wraps.
      if (vld_p1) begin
        acc_p2 <= acc_next;
        if (cnt_p2 != '1)
          cnt_p2 <= cnt_p2 + CNT_W'(1);
      end

      case (state)
        ACCUM: begin
          if (accept_p0 && bus.in_last) begin
            in_ready_r <= 1'b0;
            state      <= DRAIN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        DRAIN: begin
          // Wait one edge for the last product to land in acc_p2, then
          // publish and clear for the next vector.
          if (!(vld_p1 && last_p1)) begin
            out_result_r <= fmt_result(acc_p2);
            out_count_r  <= cnt_p2;
            out_ovf_r    <= acc_ovf(acc_p2);
            out_valid_r  <= 1'b1;
            acc_p2       <= '0;
            cnt_p2       <= '0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ACCUM;
          end
        end
        default: begin
          in_ready_r <= 1'b0;
          state      <= ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_count  = out_count_r;
  assign bus.out_ovf    = out_ovf_r;
endmodule

// File: tb/tb_vs_fp_dot_product.sv
// Self-checking bench for vs_fp_dot_product: directed scenarios plus
// randomized vectors compared against an arithmetic reference model.
module tb_vs_fp_dot_product;
  logic clock = 1'b0;
  logic reset = 1'b1;

  vs_fp_dot_product_if #(.CNT_W(16)) dif ();

  vs_fp_dot_product #(.Q(15), .ACC_W(64), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clock = ~clock;

  int n_cmp    = 0;
  int n_miscmp = 0;

  int qa[$];
  int qb[$];

  int obs_result;
  int obs_count;
  bit obs_ovf;
  int obs_lat;
  bit obs_timeout;
  bit obs_early;

  // Reference: exact products floored by 2^15, summed in 64-bit wrapping
  // arithmetic, then classified against the signed 32-bit range.
  function automatic void model(output int r, output int c, output bit o);
    longint s;
    longint p;
    s = 0;
    foreach (qa[i]) begin
      p = (longint'(qa[i]) * longint'(qb[i])) >>> 15;
      s = s + p;
    end
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef VS_FP_DOT_SAT_EN
    if (o) r = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
    else   r = int'(s);
`else
    r = int'(s);
`endif
    c = (qa.size() > 65535) ? 65535 : qa.size();
  endfunction

  // Drives the vector held in qa/qb (optionally with idle gaps), then waits
  // for out_valid and records what the DUT presented. Ends on a negedge.
  task automatic send_vector(input bit gaps);
    int i;
    int guard;
    bit wa;
    i = 0;
    guard = 0;
    obs_timeout = 1'b0;
    obs_early = 1'b0;
    while (i < qa.size()) begin
      @(negedge clock);
      if (dif.out_valid) obs_early = 1'b1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        dif.in_valid = 1'b0;
        dif.in_a     = $urandom;
        dif.in_b     = $urandom;
        dif.in_last  = 1'($urandom_range(0, 1));
      end else begin
        dif.in_valid = 1'b1;
        dif.in_a     = qa[i];
        dif.in_b     = qb[i];
        dif.in_last  = (i == qa.size() - 1);
      end
      wa = dif.in_valid && dif.in_ready;
      @(posedge clock);
      if (wa) i++;
      guard++;
      if (guard > qa.size() * 4 + 20) begin
        obs_timeout = 1'b1;
        break;
      end
    end
    obs_lat = 0;
    if (!obs_timeout) begin
      forever begin
        @(negedge clock);
        dif.in_valid = 1'b0;
        if (dif.out_valid) break;
        @(posedge clock);
        obs_lat++;
        if (obs_lat > 20) begin
          obs_timeout = 1'b1;
          break;
        end
      end
    end
    dif.in_valid = 1'b0;
    obs_result = dif.out_result;
    obs_count  = int'(dif.out_count);
    obs_ovf    = dif.out_ovf;
  endtask

  // Hands the pending result to the bench (out_ready high for the edge).
  task automatic release_result();
    dif.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b0) begin
      n_miscmp++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 0 0", dif.in_ready, dif.out_valid);
    end
    n_cmp++;
    if (dif.out_result !== 32'sd0 || dif.out_count !== 16'd0 || dif.out_ovf !== 1'b0) begin
      n_miscmp++;
      $display("FAIL reset_outputs: result=%0d count=%0d ovf=%b expected 0 0 0", dif.out_result, dif.out_count, dif.out_ovf);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (dif.in_ready !== 1'b1) begin
      n_miscmp++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", dif.in_ready);
    end
  endtask

  task automatic test_sum_squares();
    int v[9] = '{1, 2, 3, 4, 5, 4, 3, 2, 1};
    qa.delete(); qb.delete();
    foreach (v[i]) begin qa.push_back(v[i] << 15); qb.push_back(v[i] << 15); end
    dif.out_ready = 1'b1;
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_lat != 2) begin
      n_miscmp++;
      $display("FAIL sumsq_latency: got %0d (timeout=%b) expected 2", obs_lat, obs_timeout);
    end
    n_cmp++;
    if (obs_result !== (85 << 15) || obs_count !== 9 || obs_ovf !== 1'b0) begin
      n_miscmp++;
      $display("FAIL sumsq_result: got %0d/%0d/%b expected %0d/9/0", obs_result, obs_count, obs_ovf, 85 << 15);
    end
    release_result();
    n_cmp++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
      n_miscmp++;
      $display("FAIL sumsq_handoff: out_valid=%b in_ready=%b expected 0 1", dif.out_valid, dif.in_ready);
    end
  endtask

  task automatic test_signed_fraction();
    qa = '{49152}; qb = '{-73728};
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_result !== -110592 || obs_count !== 1 || obs_ovf !== 1'b0) begin
      n_miscmp++;
      $display("FAIL signed_frac: got %0d/%0d/%b expected -110592/1/0", obs_result, obs_count, obs_ovf);
    end
    release_result();
  endtask

  task automatic test_truncation();
    qa = '{1}; qb = '{1};
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_result !== 0) begin
      n_miscmp++;
      $display("FAIL trunc_pos: got %0d expected 0", obs_result);
    end
    release_result();
    qa = '{-1}; qb = '{1};
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_result !== -1) begin
      n_miscmp++;
      $display("FAIL trunc_neg: got %0d expected -1", obs_result);
    end
    release_result();
  endtask

  task automatic test_overflow();
    int exp_r;
`ifdef VS_FP_DOT_SAT_EN
    exp_r = 32'h7FFFFFFF;
`else
    exp_r = 32'h9C400000;
`endif
    qa = '{200 << 15, 200 << 15}; qb = '{200 << 15, 200 << 15};
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_result !== exp_r || obs_ovf !== 1'b1 || obs_count !== 2) begin
      n_miscmp++;
      $display("FAIL overflow: got %0d/%0d/%b expected %0d/2/1", obs_result, obs_count, obs_ovf, exp_r);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int er, ec;
    bit eo;
    qa.delete(); qb.delete();
    for (int k = 0; k < 4; k++) begin
      qa.push_back($urandom_range(0, 1 << 20) - (1 << 19));
      qb.push_back($urandom_range(0, 1 << 20) - (1 << 19));
    end
    model(er, ec, eo);
    dif.out_ready = 1'b0;
    send_vector(1'b1);
    n_cmp++;
    if (obs_timeout || obs_result !== er || obs_count !== ec || obs_ovf !== eo) begin
      n_miscmp++;
      $display("FAIL bp_result: got %0d/%0d/%b expected %0d/%0d/%b", obs_result, obs_count, obs_ovf, er, ec, eo);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (dif.out_valid !== 1'b1 || dif.out_result !== er || int'(dif.out_count) !== ec ||
          dif.out_ovf !== eo || dif.in_ready !== 1'b0) begin
        n_miscmp++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%0d count=%0d ovf=%b in_ready=%b expected 1 %0d %0d %b 0",
                 k, dif.out_valid, dif.out_result, dif.out_count, dif.out_ovf, dif.in_ready, er, ec, eo);
      end
    end
    release_result();
    n_cmp++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
      n_miscmp++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", dif.out_valid, dif.in_ready);
    end
    qa.delete(); qb.delete();
    for (int k = 0; k < 3; k++) begin
      qa.push_back($urandom_range(0, 1 << 20) - (1 << 19));
      qb.push_back($urandom_range(0, 1 << 20) - (1 << 19));
    end
    model(er, ec, eo);
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_result !== er || obs_count !== ec || obs_ovf !== eo) begin
      n_miscmp++;
      $display("FAIL bp_next: got %0d/%0d/%b expected %0d/%0d/%b", obs_result, obs_count, obs_ovf, er, ec, eo);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int acc_n;
    bit wa;
    bit seen;
    acc_n = 0;
    seen = 1'b0;
    for (int guard = 0; guard < 40 && acc_n < 4; guard++) begin
      @(negedge clock);
      if (dif.out_valid) seen = 1'b1;
      dif.in_valid = 1'b1;
      dif.in_a     = $urandom;
      dif.in_b     = $urandom;
      dif.in_last  = 1'b0;
      wa = dif.in_ready;
      @(posedge clock);
      if (wa) acc_n++;
    end
    @(negedge clock);
    dif.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    if (dif.out_valid) seen = 1'b1;
    qa = '{2 << 15, 3 << 15}; qb = '{2 << 15, 3 << 15};
    send_vector(1'b0);
    n_cmp++;
    if (seen || obs_early || acc_n != 4) begin
      n_miscmp++;
      $display("FAIL rstmid_spurious: early_valid=%b accepted=%0d expected 0 4", seen | obs_early, acc_n);
    end
    n_cmp++;
    if (obs_timeout || obs_result !== (13 << 15) || obs_count !== 2 || obs_ovf !== 1'b0) begin
      n_miscmp++;
      $display("FAIL rstmid_result: got %0d/%0d/%b expected %0d/2/0", obs_result, obs_count, obs_ovf, 13 << 15);
    end
    release_result();
  endtask

  task automatic test_random();
    int er, ec, len;
    bit eo;
    for (int v = 0; v < 30; v++) begin
      qa.delete(); qb.delete();
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if (v % 3 == 0) begin
          qa.push_back($urandom);
          qb.push_back($urandom);
        end else begin
          qa.push_back($urandom_range(0, 1 << 19) - (1 << 18));
          qb.push_back($urandom_range(0, 1 << 19) - (1 << 18));
        end
      end
      model(er, ec, eo);
      send_vector(v[0]);
      n_cmp++;
      if (obs_timeout || obs_early || obs_lat != 2) begin
        n_miscmp++;
        $display("FAIL rand_timing[%0d]: lat=%0d timeout=%b early=%b expected 2 0 0", v, obs_lat, obs_timeout, obs_early);
      end
      n_cmp++;
      if (obs_result !== er || obs_count !== ec || obs_ovf !== eo) begin
        n_miscmp++;
        $display("FAIL rand_result[%0d]: got %0d/%0d/%b expected %0d/%0d/%b", v, obs_result, obs_count, obs_ovf, er, ec, eo);
      end
      release_result();
      n_cmp++;
      if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
        n_miscmp++;
        $display("FAIL rand_handoff[%0d]: out_valid=%b in_ready=%b expected 0 1", v, dif.out_valid, dif.in_ready);
      end
    end
  endtask

  task automatic test_count_saturation();
    int er, ec;
    bit eo;
    qa.delete(); qb.delete();
    for (int k = 0; k < 65540; k++) begin
      qa.push_back(1 << 15);
      qb.push_back($urandom_range(0, 2048) - 1024);
    end
    model(er, ec, eo);
    send_vector(1'b0);
    n_cmp++;
    if (obs_timeout || obs_count !== 65535 || obs_result !== er || obs_ovf !== eo) begin
      n_miscmp++;
      $display("FAIL count_sat: got %0d/%0d/%b expected %0d/65535/%b", obs_result, obs_count, obs_ovf, er, eo);
    end
    release_result();
  endtask

  initial begin
    dif.in_valid  = 1'b0;
    dif.in_a      = '0;
    dif.in_b      = '0;
    dif.in_last   = 1'b0;
    dif.out_ready = 1'b1;
    test_reset();
    test_sum_squares();
    test_signed_fraction();
    test_truncation();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_count_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miscmp);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
